ram_loader: RTL and testbench

Upstream boot stage for the FPG8 core. Receives a framed byte stream from the serial receiver, assembles big-endian 16-bit words, and writes them into the 4096×16 program RAM through its write port. Holds the CPU in reset until the image is fully written and, optionally, checksum-verified. On completion it releases the CPU, which then starts fetching from RAM.

---
 rtl/ram_loader.sv | 181 ++++++++++++++++++
 tb/tb_ram_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// ram_loader: boot-stage loader for the FPG8 core.
// Receives a framed byte stream (count_hi, count_lo, 2*N data bytes, optional
// checksum), packs big-endian 16-bit words into the program RAM and keeps the
// CPU in reset until the whole image has been written.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// that must match the XOR of all data bytes for the load to succeed.
module ram_loader #(
   parameter logic [11:0] BASE_ADDR      = 12'h000,
   parameter int          TIMEOUT_CYCLES = 12000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        ram_w_en,
   output logic [11:0] ram_addr,
   output logic [15:0] ram_w_data,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [3:0] {
      IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, CSUM, DONE, ERROR
   } state_t;
`else
   typedef enum logic [3:0] {
      IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, DONE, ERROR
   } state_t;
`endif

   state_t state, state_next;

   logic [15:0]   count_q;
   logic [15:0]   index_q;
   logic [7:0]    hi_q;
   logic [7:0]    lo_q;
   logic [TW-1:0] timer_q;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]    csum_q;
`endif

   logic        accept;
   logic        idle_like;
   logic [15:0] index_inc;
   logic [15:0] count_rx;
   logic        count_ok;
   logic        timed_out;

   assign accept    = rx_valid && rx_ready;
   assign idle_like = (state == IDLE) || (state == DONE) || (state == ERROR);
   assign index_inc = index_q + 16'd1;
   assign count_rx  = {count_q[15:8], rx_data};
   assign count_ok  = (count_rx != 16'd0) && (count_rx <= 16'd4096);
   assign timed_out = !accept && (timer_q == TIMEOUT_LAST);

   // Handshake and status outputs decode straight from the state register,
   // so rx_ready never depends on rx_valid and reset takes effect immediately.
   always_comb begin
      rx_ready = 1'b0;
      case (state)
         CNT_HI, CNT_LO, DAT_HI, DAT_LO: rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
         CSUM:                           rx_ready = 1'b1;
`endif
         default:                        rx_ready = 1'b0;
      endcase
      busy       = !idle_like;
      ram_w_en   = (state == WRITE);
      done       = (state == DONE);
      error      = (state == ERROR);
      cpu_hold   = (state != DONE);
      ram_addr   = BASE_ADDR + index_q[11:0];
      ram_w_data = {hi_q, lo_q};
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Frame sequencing; a stalled sender during a load overrides everything with ERROR.
   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE, ERROR: begin
            if (start) state_next = CNT_HI;
         end
         CNT_HI: begin
            if (accept) state_next = CNT_LO;
         end
         CNT_LO: begin
            if (accept) state_next = count_ok ? DAT_HI : ERROR;
         end
         DAT_HI: begin
            if (accept) state_next = DAT_LO;
         end
         DAT_LO: begin
            if (accept) state_next = WRITE;
         end
         WRITE: begin
            if (index_inc == count_q) begin
`ifdef LOADER_CHECKSUM_EN
               state_next = CSUM;
`else
               state_next = DONE;
`endif
            end else begin
               state_next = DAT_HI;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CSUM: begin
            if (accept) state_next = (rx_data == csum_q) ? DONE : ERROR;
         end
`endif
         default: state_next = IDLE;
      endcase
      if (!idle_like && timed_out) state_next = ERROR;
   end

   // Datapath: byte capture, word index, idle timer and running checksum.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= 16'd0;
         index_q <= 16'd0;
         hi_q    <= 8'd0;
         lo_q    <= 8'd0;
         timer_q <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum_q  <= 8'd0;
`endif
      end else if (idle_like) begin
         if (start) begin
            index_q <= 16'd0;
            timer_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= 8'd0;
`endif
         end
      end else begin
         if (accept) begin
            timer_q <= '0;
         end else begin
            timer_q <= timer_q + 1'b1;
         end
         if (accept) begin
            case (state)
               CNT_HI: count_q[15:8] <= rx_data;
               CNT_LO: count_q[7:0]  <= rx_data;
               DAT_HI: begin
                  hi_q <= rx_data;
`ifdef LOADER_CHECKSUM_EN
                  csum_q <= csum_q ^ rx_data;
`endif
               end
               DAT_LO: begin
                  lo_q <= rx_data;
`ifdef LOADER_CHECKSUM_EN
                  csum_q <= csum_q ^ rx_data;
`endif
               end
               default: ;
            endcase
         end
         if (state == WRITE) index_q <= index_inc;
      end
   end

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: randomized frame-level bench for ram_loader.
// The stimulus thread builds frames and queues the RAM writes each frame should
// produce; an independent monitor pops and compares whenever ram_w_en is seen.
module tb_ram_loader;

   localparam logic [11:0] BASE = 12'hFFE;
   localparam int          TMO  = 100;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        ram_w_en;
   logic [11:0] ram_addr;
   logic [15:0] ram_w_data;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        error;

   ram_loader #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .start(start),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .ram_w_en(ram_w_en), .ram_addr(ram_addr), .ram_w_data(ram_w_data),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
   );

   // Free-running 100 MHz-style clock.
   always #5 clk = ~clk;

   typedef struct packed {
      logic [11:0] addr;
      logic [15:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic [15:0] fixed_words[$];
   int          compared   = 0;
   int          mismatched = 0;
   int          frame_id   = 0;
   bit          stream_mode = 1'b0;
   int          cycle      = 0;
   int          last_frame = -1;
   int          last_cycle = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Cycle counter used to measure spacing between consecutive writes.
   always @(posedge clk) cycle++;

   // Monitor: every observed write must match the next queued expectation.
   always @(negedge clk) begin
      if (reset === 1'b1 && ram_w_en === 1'b1) begin
         wr_t e;
         check("ready_low_in_write", rx_ready, 0);
         check("hold_during_write", cpu_hold, 1);
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_write actual=%h:%h required=no_write", ram_addr, ram_w_data);
         end else begin
            e = exp_q.pop_front();
            check("write_addr", ram_addr, e.addr);
            check("write_data", ram_w_data, e.data);
         end
         if (stream_mode && last_frame == frame_id)
            check("write_spacing", cycle - last_cycle, 3);
         last_frame = frame_id;
         last_cycle = cycle;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_reset_values();
      check("rst_rx_ready", rx_ready, 0);
      check("rst_ram_w_en", ram_w_en, 0);
      check("rst_ram_addr", ram_addr, BASE);
      check("rst_ram_w_data", ram_w_data, 0);
      check("rst_cpu_hold", cpu_hold, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Present one byte and hold it until the loader takes it (bounded wait).
   task automatic send_byte(input logic [7:0] b);
      int w = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (rx_ready !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (rx_ready !== 1'b1) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL ready_wait actual=%b required=1", rx_ready);
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic check_output(input bit expect_ok);
      int k = 0;
      while (done !== 1'b1 && error !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("end_done", done, expect_ok);
      check("end_error", error, !expect_ok);
      check("end_cpu_hold", cpu_hold, !expect_ok);
      check("end_busy", busy, 0);
      check("queue_drained", exp_q.size(), 0);
      idle(2);
   endtask

   // One complete frame: the model says a load succeeds iff 1<=N<=4096 and,
   // with the checksum enabled, the trailing byte equals the XOR of all data.
   task automatic apply_stimulus(input int n, input bit bad_csum, input bit stream,
                                 input bit mid_start, input int long_gap_word);
      logic [15:0] cnt;
      logic [15:0] w;
      logic [7:0]  x;
      bit          ok;
      cnt = 16'(n);
      x   = 8'h00;
      ok  = (n >= 1) && (n <= 4096);
      frame_id++;
      stream_mode = stream;
      pulse_start();
      check("start_busy", busy, 1);
      check("start_cleared_done", done, 0);
      check("start_cleared_error", error, 0);
      send_byte(cnt[15:8]);
      send_byte(cnt[7:0]);
      if (ok) begin
         for (int i = 0; i < n; i++) begin
            if (fixed_words.size() == n) w = fixed_words[i];
            else w = 16'($urandom);
            x = x ^ w[15:8] ^ w[7:0];
            exp_q.push_back('{addr: 12'((int'(BASE) + i) % 4096), data: w});
            if (i == long_gap_word) idle(TMO - 10);
            send_byte(w[15:8]);
            if (!stream) idle($urandom_range(0, 3));
            if (mid_start && i == 0) begin
               start = 1'b1;
               @(negedge clk);
               start = 1'b0;
            end
            send_byte(w[7:0]);
            if (!stream) idle($urandom_range(0, 3));
         end
`ifdef LOADER_CHECKSUM_EN
         if (bad_csum) begin
            send_byte(x ^ 8'(1 + $urandom_range(0, 254)));
            ok = 1'b0;
         end else begin
            send_byte(x);
         end
`endif
      end
      check_output(ok);
   endtask

   task automatic timeout_frame();
      frame_id++;
      stream_mode = 1'b0;
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'(($urandom)));
      idle(TMO + 5);
      check("tmo_error", error, 1);
      check("tmo_done", done, 0);
      check("tmo_cpu_hold", cpu_hold, 1);
      check("tmo_busy", busy, 0);
      check("tmo_no_write", exp_q.size(), 0);
      idle(2);
   endtask

   task automatic reset_abort_frame();
      logic [15:0] w;
      frame_id++;
      stream_mode = 1'b0;
      w = 16'($urandom) | 16'h0101;
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h03);
      exp_q.push_back('{addr: BASE, data: w});
      send_byte(w[15:8]);
      send_byte(w[7:0]);
      send_byte(8'hA5);
      idle(1);
      #3 reset = 1'b0;
      #1 check_reset_values();
      exp_q.delete();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_values();
   endtask

   // Main stimulus sequence.
   initial begin
      reset    = 1'b0;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      idle(3);
      check_reset_values();
      reset = 1'b1;
      idle(2);
      check_reset_values();

      fixed_words = '{16'h1234, 16'hABCD};
      apply_stimulus(2, 1'b0, 1'b1, 1'b0, -1);
`ifdef LOADER_CHECKSUM_EN
      apply_stimulus(2, 1'b1, 1'b0, 1'b0, -1);
`endif
      fixed_words.delete();

      apply_stimulus(0, 1'b0, 1'b0, 1'b0, -1);
      apply_stimulus(4097, 1'b0, 1'b0, 1'b0, -1);
      apply_stimulus(16'hFFFF, 1'b0, 1'b1, 1'b0, -1);
      timeout_frame();
      apply_stimulus(3, 1'b0, 1'b0, 1'b0, 1);
      apply_stimulus(20, 1'b0, 1'b1, 1'b0, -1);
      apply_stimulus(4, 1'b0, 1'b0, 1'b1, -1);
      reset_abort_frame();

      for (int f = 0; f < 12; f++) begin
         int  n;
         bit  bad;
         bit  strm;
         n    = 1 + $urandom_range(0, 7);
         bad  = ($urandom_range(0, 3) == 0);
         strm = ($urandom_range(0, 1) == 1);
         apply_stimulus(n, bad, strm, !strm && ($urandom_range(0, 2) == 0), -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Hang guard.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] simulation time limit");
   end

endmodule
